// File: rtl/accel_pkg.sv
// Shared datapath types and widths for the accelerator arithmetic blocks.
package accel_pkg;

    localparam int unsigned SUB_WIDTH = 15;

    typedef logic [SUB_WIDTH-1:0] sub_word_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/subtractor_module.sv
// Registered ripple-borrow subtractor: DIFF = X - Y - Bin, qualified by OE one cycle after DE.
module subtractor_module
    import accel_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             DE,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             OE,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             oe_q;

    assign borrow[0] = Bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_subtractor u_fs (
            .x    (X[i]),
            .y    (Y[i]),
            .bin  (borrow[i]),
            .d    (diff_d[i]),
            .bout (borrow[i+1])
        );
    end

    // Result registers only load on accepted operands so idle cycles hold the last value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            diff_q <= '0;
            bout_q <= 1'b0;
            oe_q   <= 1'b0;
        end else begin
            oe_q <= DE;
            if (DE) begin
                diff_q <= diff_d;
                bout_q <= borrow[WIDTH];
            end
        end
    end

    assign OE   = oe_q;
    assign DIFF = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_subtractor_module.sv
// Directed self-checking bench for the registered 15-bit subtractor.
module tb_subtractor_module;
    import accel_pkg::*;

    logic      CLK;
    logic      RST_N;
    logic      DE;
    sub_word_t X;
    sub_word_t Y;
    logic      Bin;
    logic      OE;
    sub_word_t DIFF;
    logic      Bout;

    int n_pass;
    int n_total;

    subtractor_module #(
        .WIDTH (SUB_WIDTH)
    ) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .DE    (DE),
        .X     (X),
        .Y     (Y),
        .Bin   (Bin),
        .OE    (OE),
        .DIFF  (DIFF),
        .Bout  (Bout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_out(input string tag, input logic e_oe, input int e_diff,
                             input logic e_bout);
        check({tag, ".oe"}, 32'(OE), 32'(e_oe));
        check({tag, ".diff"}, 32'(DIFF), e_diff);
        check({tag, ".bout"}, 32'(Bout), 32'(e_bout));
    endtask

    task automatic drive(input logic de, input int x, input int y, input logic b);
        DE  = de;
        X   = sub_word_t'(x);
        Y   = sub_word_t'(y);
        Bin = b;
    endtask

    // Streaming vectors: x, y, bin, expected diff, expected bout.
    int st_x[4]    = '{10, 10, 5, 0};
    int st_y[4]    = '{3, 3, 5, 1};
    int st_b[4]    = '{0, 1, 0, 0};
    int st_diff[4] = '{7, 6, 0, 32767};
    int st_bout[4] = '{0, 0, 0, 1};

    initial begin
        n_pass  = 0;
        n_total = 0;
        RST_N   = 1'b0;
        drive(1'b0, 0, 0, 1'b0);

        #2;
        check_out("reset", 1'b0, 0, 1'b0);

        // Release at a falling edge; idle with random operands.
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)),
                  1'($urandom_range(0, 1)));
            @(negedge CLK);
            check_out("idle", 1'b0, 0, 1'b0);
        end

        drive(1'b1, 50, 20, 1'b0);
        @(negedge CLK);
        check_out("basic", 1'b1, 30, 1'b0);
        drive(1'b0, 1234, 4321, 1'b1);
        @(negedge CLK);
        check_out("hold", 1'b0, 30, 1'b0);

        drive(1'b1, 20, 50, 1'b0);
        @(negedge CLK);
        check_out("underflow", 1'b1, 32738, 1'b1);

        drive(1'b1, 0, 0, 1'b1);
        @(negedge CLK);
        check_out("bin_wrap", 1'b1, 32767, 1'b1);

        drive(1'b1, 32767, 32767, 1'b0);
        @(negedge CLK);
        check_out("max_eq", 1'b1, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, st_x[i], st_y[i], st_b[i]);
            @(negedge CLK);
            check_out($sformatf("stream%0d", i), 1'b1, st_diff[i], 1'(st_bout[i]));
        end
        drive(1'b0, 0, 0, 1'b0);
        @(negedge CLK);
        check_out("stream_end", 1'b0, 32767, 1'b1);

        // Async reset between edges while a result is being presented.
        drive(1'b1, 50, 20, 1'b0);
        @(negedge CLK);
        check_out("pre_rst", 1'b1, 30, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 0, 1'b0);
        drive(1'b1, 9, 4, 1'b0);
        @(negedge CLK);
        check_out("in_rst", 1'b0, 0, 1'b0);
        drive(1'b0, 9, 4, 1'b0);
        RST_N = 1'b1;
        @(negedge CLK);
        check_out("post_rst", 1'b0, 0, 1'b0);
        drive(1'b1, 7, 2, 1'b0);
        @(negedge CLK);
        check_out("restart", 1'b1, 5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/subtractor_module.md
Name: subtractor_module

Overview:
- Registered 15-bit ripple-borrow subtractor for the accelerator datapath.
- Computes DIFF = X − Y − Bin and a borrow-out on each data-enabled clock edge.
- Asserts OE one cycle later to qualify the registered result.
- Sits between operand sources and downstream consumers, which sample DIFF/Bout when OE=1.

Parameters:
- WIDTH, 15, operand and result width in bits.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- DE  input  1  data enable; operands are valid and captured when high at a CLK rising edge.
- X  input  WIDTH  minuend, unsigned.
- Y  input  WIDTH  subtrahend, unsigned.
- Bin  input  1  borrow-in.
- OE  output  1  output enable; high for the cycle after each accepted DE.
- DIFF  output  WIDTH  registered difference.
- Bout  output  1  registered borrow-out.

Behaviour:
- Interface: one clock (CLK); reset RST_N is asynchronous and active-low.
- Reset: while RST_N=0, DIFF=0, Bout=0 and OE=0 immediately, independent of CLK. Release takes effect at the next rising edge.
- Combinational core: ripple chain of WIDTH full-subtractor cells.
  - Cell i: d_i = x_i ^ y_i ^ b_i; b_{i+1} = (~x_i & y_i) | (~(x_i ^ y_i) & b_i).
  - b_0 = Bin; borrow-out = b_WIDTH.
- Arithmetic: DIFF = (X − Y − Bin) mod 2^WIDTH. Bout = 1 iff X < Y + Bin (unsigned), i.e. the result wrapped.
- Capture: on a rising edge with DE=1, register DIFF and Bout from the core, and set OE=1.
- Idle: on a rising edge with DE=0, OE=0; DIFF and Bout hold their last values.
- Latency: exactly 1 cycle from DE sample to OE/DIFF/Bout valid.
- Throughput: one result per cycle. DE held high gives OE continuously high, with DIFF updating every cycle.
- X, Y and Bin are don't-care when DE=0 and must not affect any output.
- Reset asserted mid-operation: a pending result is discarded; outputs go to 0 immediately and OE stays 0 until a new DE is accepted after release.
- No handshake back-pressure: the consumer must sample DIFF/Bout on the OE cycle or use the held value.

Decomposition:
- Shared package (accel_pkg): localparam SUB_WIDTH = 15; typedef logic [SUB_WIDTH-1:0] sub_word_t.
- Sub-module full_subtractor (x, y, bin → d, bout), instantiated WIDTH times via generate to form the ripple chain.
- The top level holds only the chain and the output registers.

Test Plan:
- Reset/idle: RST_N=0 then 1, DE=0 with random X/Y for 5 cycles → OE=0, DIFF=0, Bout=0 throughout.
- Basic: DE=1, X=50, Y=20, Bin=0 → next cycle OE=1, DIFF=30, Bout=0; with DE=0 the following cycle → OE=0, DIFF holds 30.
- Underflow: DE=1, X=20, Y=50, Bin=0 → DIFF=32738, Bout=1, OE=1.
- Borrow-in edge: DE=1, X=0, Y=0, Bin=1 → DIFF=32767, Bout=1. Then X=32767, Y=32767, Bin=0 → DIFF=0, Bout=0.
- Streaming: DE held high for 4 cycles with (X,Y,Bin) = (10,3,0), (10,3,1), (5,5,0), (0,1,0) → OE high 4 consecutive cycles, DIFF = 7, 6, 0, 32767 and Bout = 0, 0, 0, 1, each one cycle after its input.
- Async reset: assert RST_N=0 between edges while OE=1, DIFF=30 → outputs drop to 0 before the next edge and stay 0 until DE is accepted after release.
